// File: rtl/uram_readout_pkg.sv
// Shared types and constants for the URAM/BRAM event readout sequencer.
package uram_readout_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SWITCH = 2'd1,
      READ   = 2'd2,
      DRAIN  = 2'd3
   } state_t;

   localparam int BRAMS_PER_CHAN = 3;
   localparam int ADDRS_PER_BRAM = 512;
   localparam int BUF_W          = 3;
   localparam int ADDR_W         = 9;
   localparam int BRAM_W         = 2;
   localparam int RADDR_W        = BUF_W + ADDR_W;

endpackage

// File: rtl/uram_readout_casmux.sv
// Decodes the flat source BRAM index into a one-hot read enable and a
// thermometer cascade select (every BRAM downstream of the source passes
// cascade data through).
module uram_readout_casmux
   import uram_readout_pkg::*;
#(
   parameter int NB = 24,
   parameter int SW = 5
)
(
   input  logic [SW-1:0] src,
   output logic [NB-1:0] en_onehot,
   output logic [NB-1:0] therm
);

   // One-hot at the source, ones strictly above it.
   always_comb begin
      en_onehot = '0;
      therm     = '0;
      for (int unsigned j = 0; j < NB; j++) begin
         en_onehot[j] = (SW'(j) == src);
         therm[j]     = (SW'(j) > src);
      end
   end

endmodule

// File: rtl/uram_event_readout_ctrl.sv
// Read-side sequencer for a cascaded chain of NCHAN event channel buffers.
// Streams one 1536-byte slice per channel (A, B, C) out of the chain end.
// Optional build macro: URAM_READOUT_CHMASK_EN adds chmask_i to skip channels.
module uram_event_readout_ctrl
   import uram_readout_pkg::*;
#(
   parameter int NCHAN        = 8,
   parameter int READ_LATENCY = 2
)
(
   input  logic                  ifclk_i,
   input  logic                  ifclk_rst_i,
   input  logic                  req_i,
   input  logic [2:0]            buf_i,
`ifdef URAM_READOUT_CHMASK_EN
   input  logic [NCHAN-1:0]      chmask_i,
`endif
   output logic                  busy_o,
   output logic                  done_o,
   output logic [3*NCHAN-1:0]    bram_en_o,
   output logic [3*NCHAN-1:0]    bram_casdomux_o,
   output logic [3*NCHAN-1:0]    bram_casdomuxen_o,
   output logic                  bram_regce_o,
   output logic [11:0]           bram_raddr_o,
   output logic                  dout_valid_o
);

   localparam int NB  = BRAMS_PER_CHAN * NCHAN;
   localparam int SW  = $clog2(NB);
   localparam int CHW = (NCHAN > 1) ? $clog2(NCHAN) : 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(ADDRS_PER_BRAM - 1);
   localparam logic [BRAM_W-1:0] LAST_BRAM  = BRAM_W'(BRAMS_PER_CHAN - 1);
   localparam logic [7:0]        DRAIN_LAST = 8'(READ_LATENCY - 1);

   state_t                  state_q, state_d;
   logic [BUF_W-1:0]        buf_q;
   logic [CHW-1:0]          ch_q;
   logic [BRAM_W-1:0]       bram_q;
   logic [ADDR_W-1:0]       addr_q;
   logic [7:0]              drain_q;
   logic [NB-1:0]           casmux_q;
   logic [READ_LATENCY-1:0] vld_sr;
   logic                    done_q;
`ifdef URAM_READOUT_CHMASK_EN
   logic [NCHAN-1:0]        mask_q;
`endif

   logic [CHW-1:0] first_ch, next_ch;
   logic           any_ch, has_next;
   logic [SW-1:0]  src;
   logic [NB-1:0]  en_onehot, therm;
   logic           last_addr, last_bram;

   assign src       = SW'(ch_q) * SW'(BRAMS_PER_CHAN) + SW'(bram_q);
   assign last_addr = (addr_q == LAST_ADDR);
   assign last_bram = (bram_q == LAST_BRAM);

   uram_readout_casmux #(
      .NB (NB),
      .SW (SW)
   ) u_casmux (
      .src       (src),
      .en_onehot (en_onehot),
      .therm     (therm)
   );

`ifdef URAM_READOUT_CHMASK_EN
   // Lowest enabled channel at request time, and next enabled channel after ch_q.
   // Scanning downward lets the lowest qualifying index win.
   always_comb begin
      first_ch = '0;
      any_ch   = 1'b0;
      next_ch  = '0;
      has_next = 1'b0;
      for (int unsigned c = NCHAN; c > 0; c--) begin
         if (chmask_i[c-1]) begin
            first_ch = CHW'(c - 1);
            any_ch   = 1'b1;
         end
         if (mask_q[c-1] && (CHW'(c - 1) > ch_q)) begin
            next_ch  = CHW'(c - 1);
            has_next = 1'b1;
         end
      end
   end
`else
   // Every channel is read in chain order.
   always_comb begin
      first_ch = '0;
      any_ch   = 1'b1;
      has_next = (ch_q != CHW'(NCHAN - 1));
      next_ch  = ch_q + CHW'(1);
   end
`endif

   // State register.
   always_ff @(posedge ifclk_i or posedge ifclk_rst_i) begin
      if (ifclk_rst_i) state_q <= IDLE;
      else             state_q <= state_d;
   end

   // Next-state decode.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (req_i) state_d = any_ch ? SWITCH : DRAIN;
         SWITCH:  state_d = READ;
         READ: begin
            if (last_addr && last_bram && !has_next) state_d = DRAIN;
            else if (last_addr)                      state_d = SWITCH;
         end
         DRAIN:   if (drain_q == DRAIN_LAST) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Channel/BRAM/address counters, captured request, held cascade select, done pulse.
   always_ff @(posedge ifclk_i or posedge ifclk_rst_i) begin
      if (ifclk_rst_i) begin
         buf_q    <= '0;
         ch_q     <= '0;
         bram_q   <= '0;
         addr_q   <= '0;
         drain_q  <= '0;
         casmux_q <= '0;
         done_q   <= 1'b0;
`ifdef URAM_READOUT_CHMASK_EN
         mask_q   <= '0;
`endif
      end else begin
         done_q <= (state_q == DRAIN) && (drain_q == DRAIN_LAST);
         unique case (state_q)
            IDLE: begin
               if (req_i) begin
                  buf_q   <= buf_i;
                  ch_q    <= first_ch;
                  bram_q  <= '0;
                  addr_q  <= '0;
                  drain_q <= '0;
`ifdef URAM_READOUT_CHMASK_EN
                  mask_q  <= chmask_i;
`endif
               end
            end
            SWITCH: casmux_q <= therm;
            READ: begin
               addr_q <= addr_q + ADDR_W'(1);
               if (last_addr) begin
                  if (!last_bram) begin
                     bram_q <= bram_q + BRAM_W'(1);
                  end else begin
                     bram_q <= '0;
                     if (has_next) ch_q <= next_ch;
                  end
               end
            end
            DRAIN:   drain_q <= drain_q + 8'd1;
            default: ;
         endcase
      end
   end

   // Valid delay line matching BRAM read plus output register latency.
   always_ff @(posedge ifclk_i or posedge ifclk_rst_i) begin
      if (ifclk_rst_i) begin
         vld_sr <= '0;
      end else begin
         vld_sr[0] <= (state_q == READ);
         for (int unsigned k = 1; k < READ_LATENCY; k++) vld_sr[k] <= vld_sr[k-1];
      end
   end

   // State-decoded outputs; the cascade select shows the new value during SWITCH
   // and the registered copy otherwise.
   always_comb begin
      busy_o            = (state_q != IDLE);
      bram_en_o         = (state_q == READ) ? en_onehot : '0;
      bram_casdomux_o   = (state_q == SWITCH) ? therm : casmux_q;
      bram_casdomuxen_o = (state_q == SWITCH) ? '1 : '0;
      bram_regce_o      = (state_q == READ) || (state_q == DRAIN);
      bram_raddr_o      = (state_q == READ) ? {buf_q, addr_q} : '0;
   end

   assign dout_valid_o = vld_sr[READ_LATENCY-1];
   assign done_o       = done_q;

endmodule

// File: tb/tb_uram_event_readout_ctrl.sv
// Self-checking bench for uram_event_readout_ctrl (NCHAN=2, READ_LATENCY=2).
// Expected per-cycle behaviour is a flat trace built from the readout rules.
module tb_uram_event_readout_ctrl;

   localparam int NCHAN = 2;
   localparam int RL    = 2;
   localparam int NB    = 3 * NCHAN;

   logic              clk = 1'b0;
   logic              rst;
   logic              req;
   logic [2:0]        bufi;
`ifdef URAM_READOUT_CHMASK_EN
   logic [NCHAN-1:0]  chm;
`endif
   logic              busy, done, regce, valid;
   logic [NB-1:0]     en, casmux, casmuxen;
   logic [11:0]       raddr;

   int nchk = 0;
   int nerr = 0;

   typedef struct {
      bit rd;
      bit sw;
      bit drn;
      bit dn;
      int s;
      int a;
   } ent_t;

   ent_t          tr[$];
   logic [NB-1:0] held;

   uram_event_readout_ctrl #(
      .NCHAN        (NCHAN),
      .READ_LATENCY (RL)
   ) dut (
      .ifclk_i           (clk),
      .ifclk_rst_i       (rst),
      .req_i             (req),
      .buf_i             (bufi),
`ifdef URAM_READOUT_CHMASK_EN
      .chmask_i          (chm),
`endif
      .busy_o            (busy),
      .done_o            (done),
      .bram_en_o         (en),
      .bram_casdomux_o   (casmux),
      .bram_casdomuxen_o (casmuxen),
      .bram_regce_o      (regce),
      .bram_raddr_o      (raddr),
      .dout_valid_o      (valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      nchk++;
      assert (obs === exp_v) else begin
         nerr++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
      end
   endtask

   function automatic logic [NB-1:0] therm_of(input int s);
      logic [31:0] t;
      t = 32'hFFFF_FFFF << (s + 1);
      return t[NB-1:0];
   endfunction

   // Expected trace from acceptance to done: per enabled channel, per BRAM,
   // one switch cycle then 512 reads; then the drain cycles and the done cycle.
   task automatic build(input logic [NCHAN-1:0] m);
      ent_t e;
      tr.delete();
      for (int c = 0; c < NCHAN; c++) begin
         if (m[c]) begin
            for (int b = 0; b < 3; b++) begin
               e = '{rd: 1'b0, sw: 1'b1, drn: 1'b0, dn: 1'b0, s: 3*c+b, a: 0};
               tr.push_back(e);
               for (int a = 0; a < 512; a++) begin
                  e = '{rd: 1'b1, sw: 1'b0, drn: 1'b0, dn: 1'b0, s: 3*c+b, a: a};
                  tr.push_back(e);
               end
            end
         end
      end
      for (int d = 0; d < RL; d++) begin
         e = '{rd: 1'b0, sw: 1'b0, drn: 1'b1, dn: 1'b0, s: 0, a: 0};
         tr.push_back(e);
      end
      e = '{rd: 1'b0, sw: 1'b0, drn: 1'b0, dn: 1'b1, s: 0, a: 0};
      tr.push_back(e);
   endtask

   task automatic check_entry(input int i, input logic [2:0] b);
      ent_t        e;
      logic [11:0] ra;
      bit          vexp;
      e = tr[i];
      if (e.sw) held = therm_of(e.s);
      vexp = 1'b0;
      if (i >= RL) vexp = tr[i-RL].rd;
      chk("busy",       32'(busy),     32'(!e.dn));
      chk("done",       32'(done),     32'(e.dn));
      chk("bram_en",    32'(en),       e.rd ? (32'(1) << e.s) : 32'(0));
      chk("casdomuxen", 32'(casmuxen), e.sw ? 32'({NB{1'b1}}) : 32'(0));
      chk("casdomux",   32'(casmux),   32'(held));
      chk("regce",      32'(regce),    32'(e.rd | e.drn));
      chk("dout_valid", 32'(valid),    32'(vexp));
      if (e.rd) begin
         ra = {b, 9'(e.a)};
         chk("raddr", 32'(raddr), 32'(ra));
      end
   endtask

   task automatic idle_check(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk("idle_busy",     32'(busy),     32'(0));
         chk("idle_done",     32'(done),     32'(0));
         chk("idle_en",       32'(en),       32'(0));
         chk("idle_casmuxen", 32'(casmuxen), 32'(0));
         chk("idle_casmux",   32'(casmux),   32'(held));
         chk("idle_regce",    32'(regce),    32'(0));
         chk("idle_valid",    32'(valid),    32'(0));
      end
   endtask

   // Issue a request at the current negedge and follow it to done.
   // hold keeps req_i high; poke pulses req_i (ignored) at that trace index.
   task automatic run_req(input logic [2:0] b, input logic [NCHAN-1:0] m,
                          input bit hold, input int poke);
      int vcnt, swcnt, dn_at, nsel;
      build(m);
      nsel  = $countones(m);
      req   = 1'b1;
      bufi  = b;
`ifdef URAM_READOUT_CHMASK_EN
      chm   = m;
`endif
      vcnt  = 0;
      swcnt = 0;
      dn_at = -1;
      for (int i = 0; i < tr.size(); i++) begin
         @(negedge clk);
         check_entry(i, b);
         if (valid) vcnt++;
         if (casmuxen != '0) swcnt++;
         if (done && dn_at < 0) dn_at = i;
         if (i == 0 && !hold) req = 1'b0;
         if (i == poke) begin
            req  = 1'b1;
            bufi = 3'($urandom);
         end else if (i == poke + 1 && !hold) begin
            req = 1'b0;
         end
      end
      chk("valid_count",     32'(vcnt),      32'(1536 * nsel));
      chk("casmuxen_pulses", 32'(swcnt),     32'(3 * nsel));
      chk("done_cycle",      32'(dn_at + 1), 32'(nsel * 3 * 513 + RL + 1));
   endtask

   initial begin
      logic [2:0] rb;
      rst  = 1'b1;
      req  = 1'b0;
      bufi = '0;
      held = '0;
`ifdef URAM_READOUT_CHMASK_EN
      chm  = '1;
`endif
      repeat (3) @(negedge clk);
      chk("rst_busy",   32'(busy),     32'(0));
      chk("rst_done",   32'(done),     32'(0));
      chk("rst_en",     32'(en),       32'(0));
      chk("rst_casmux", 32'(casmux),   32'(0));
      chk("rst_casen",  32'(casmuxen), 32'(0));
      chk("rst_regce",  32'(regce),    32'(0));
      chk("rst_raddr",  32'(raddr),    32'(0));
      chk("rst_valid",  32'(valid),    32'(0));
      rst = 1'b0;
      idle_check(3);

      // Basic readout of buffer 5.
      run_req(3'd5, '1, 1'b0, -1);
      idle_check(int'($urandom_range(2, 8)));

      // Random buffer with an ignored request pulse in mid-readout.
      run_req(3'($urandom), '1, 1'b0, int'($urandom_range(10, 2500)));
      idle_check(20);

      // req held high: second readout starts the cycle after done.
      rb = 3'($urandom);
      run_req(rb, '1, 1'b1, -1);
      run_req(rb, '1, 1'b0, -1);
      idle_check(5);

`ifdef URAM_READOUT_CHMASK_EN
      run_req(3'($urandom), 2'b10, 1'b0, -1);
      idle_check(4);
      run_req(3'($urandom), 2'b00, 1'b0, -1);
      idle_check(4);
      chm = '1;
`endif

      // Asynchronous reset in the middle of a readout (address 200 of BRAM A).
      build('1);
      req  = 1'b1;
      bufi = 3'd3;
      for (int i = 0; i <= 201; i++) begin
         @(negedge clk);
         check_entry(i, 3'd3);
         if (i == 0) req = 1'b0;
      end
      rst = 1'b1;
      #1;
      chk("arst_busy",   32'(busy),     32'(0));
      chk("arst_done",   32'(done),     32'(0));
      chk("arst_en",     32'(en),       32'(0));
      chk("arst_casmux", 32'(casmux),   32'(0));
      chk("arst_casen",  32'(casmuxen), 32'(0));
      chk("arst_regce",  32'(regce),    32'(0));
      chk("arst_raddr",  32'(raddr),    32'(0));
      chk("arst_valid",  32'(valid),    32'(0));
      held = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      idle_check(20);

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
